clic_dispatch: RTL and testbench
================================

Name: clic_dispatch

Overview:
- Sequential interrupt dispatcher around the CAN-style CLIC arbitration scheme.
- Holds per-line pending, enable and priority state and runs bit-serial wired-OR arbitration: priority bits MSB first, then index bits MSB first for tie-break.
- Offers the winner to the core with a valid/ack claim handshake.
- Tracks nested handlers on a threshold stack, popped by a completion strobe.

Parameters:
NR_INDEX_BITS, common_pkg::NR_INDEX_BITS, index width; 2**NR_INDEX_BITS slots; slot 2**NR_INDEX_BITS-1 is reserved as the threshold slot, so NR_LINES = 2**NR_INDEX_BITS-1.
NR_PRIO_BITS, common_pkg::NR_PRIO_BITS, priority width; 0 is lowest.
NEST_DEPTH, 4, threshold stack entries.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
irq_req  in  NR_LINES  level request per line; sets pending on every edge where high.
cfg_we  in  1  config write strobe.
cfg_idx  in  NR_INDEX_BITS  line to configure; writes to the reserved index are ignored.
cfg_prio  in  NR_PRIO_BITS  priority to write.
cfg_en  in  1  enable to write.
irq_valid  out  1  winner offered.
irq_index  out  NR_INDEX_BITS  offered line.
irq_prio  out  NR_PRIO_BITS  offered priority.
irq_ack  in  1  claim; handshake when irq_valid & irq_ack.
irq_done  in  1  handler complete; pops the stack.
threshold  out  NR_PRIO_BITS  current running priority.
nest_depth  out  $clog2(NEST_DEPTH+1)  stack occupancy.
busy  out  1  FSM not IDLE.

Behaviour:
- Reset: all pending/enable/priority registers 0; stack empty; threshold 0; FSM IDLE; all outputs 0.
- Config: a write with cfg_we=1 updates prio[cfg_idx] and en[cfg_idx] at the edge. It does not affect an arbitration already in progress, because priorities are snapshotted.
- Pending: pend[i] is set on any edge with irq_req[i]=1. It is cleared only on a handshake for line i. If a set and a clear occur on the same edge, set wins.
- Contender snapshot, taken on entering ARB_PRIO:
  - c[i] = pend[i] & en[i] for each line.
  - c[reserved] = 1, with its priority equal to threshold.
  - Line priorities are latched at the same time.
- FSM:
  - IDLE: if any pend&en and nest_depth<NEST_DEPTH, take the snapshot and go to ARB_PRIO (step = NR_PRIO_BITS-1). Otherwise stay in IDLE.
  - ARB_PRIO, one bit per cycle:
    - or = OR over contenders of prio[pb].
    - If or=1, contenders with prio[pb]=0 drop.
    - After bit 0, go to ARB_IDX.
  - ARB_IDX, one bit per cycle, same rule applied to index bit ib. The higher index wins ties, so the reserved slot wins equal-priority ties: a line preempts only when strictly above threshold.
  - After index bit 0 exactly one contender remains:
    - If it is the reserved slot, go to IDLE.
    - Otherwise go to OFFER and drive irq_valid=1, irq_index, and irq_prio from registers.
  - Arbitration latency: irq_valid rises NR_PRIO_BITS+NR_INDEX_BITS+1 edges after the edge that set pending, when the FSM starts from IDLE.
  - OFFER: hold irq_valid, irq_index and irq_prio stable until one of:
    - Handshake: clear pend[idx]; push threshold; threshold <= irq_prio; depth+1; go to IDLE with irq_valid=0 next cycle.
    - irq_done=1: pop (see below); withdraw the offer; go to IDLE. An irq_ack asserted in the same cycle is ignored.
- irq_done in any state:
  - If depth>0: threshold <= top; depth-1.
  - If depth=0: ignored.
  - Arbitration in progress is not restarted; the next IDLE pass uses the new threshold.
- Stack full (depth=NEST_DEPTH): IDLE does not start arbitration until a pop.
- Requests arriving during ARB/OFFER are latched but excluded from the current snapshot. They are considered on the next IDLE pass.
- Multiple-winner or zero-winner after ARB_IDX is impossible by construction. An immediate assertion flags it.
- busy=1 in ARB_PRIO, ARB_IDX and OFFER.

Test Plan:
All scenarios use NR_INDEX_BITS=3, NR_PRIO_BITS=3 (lines 0..6, slot 7 reserved).
- Reset: assert rst asynchronously mid-cycle -> irq_valid, threshold, nest_depth and busy are 0 immediately. After release with no requests, IDLE persists.
- Single line: cfg line 2 prio 5 en 1; pulse irq_req[2] one cycle -> irq_valid=1, irq_index=2, irq_prio=5 exactly 7 edges later. Ack -> threshold=5, nest_depth=1, irq_valid=0 next cycle.
- Tie: lines 3 and 5 at prio 4, both requested together -> line 5 offered first. After ack, threshold=4 and line 3 is not offered (equal priority). irq_done -> threshold=0, then line 3 offered.
- Preemption: line 1 prio 2 acked (threshold=2); request line 6 prio 6 -> offered and acked, nest_depth=2, threshold=6. irq_done twice -> threshold 2, then 0, nest_depth 0.
- Gating and full stack:
  - Line 4 pending with en=0 -> no offer. Enabling it via cfg -> offer 7 edges later.
  - With NEST_DEPTH=1 and one handler active, a higher-priority request is not offered until irq_done.
- Offer withdrawal: irq_done and irq_ack asserted together while offering line 2 -> pend[2] stays 1, depth decrements, line 2 is re-offered after re-arbitration.

Source files
------------

// File: rtl/clic_dispatch.sv
// CLIC-style interrupt dispatcher: bit-serial wired-OR arbitration,
// valid/ack claim handshake and a nested threshold stack.
package common_pkg;
  localparam int NR_INDEX_BITS = 3;
  localparam int NR_PRIO_BITS  = 3;
endpackage

module clic_dispatch #(
  parameter int NR_INDEX_BITS = common_pkg::NR_INDEX_BITS,
  parameter int NR_PRIO_BITS  = common_pkg::NR_PRIO_BITS,
  parameter int NEST_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [2**NR_INDEX_BITS-2:0]      irq_req,
  input  logic                             cfg_we,
  input  logic [NR_INDEX_BITS-1:0]         cfg_idx,
  input  logic [NR_PRIO_BITS-1:0]          cfg_prio,
  input  logic                             cfg_en,
  output logic                             irq_valid,
  output logic [NR_INDEX_BITS-1:0]         irq_index,
  output logic [NR_PRIO_BITS-1:0]          irq_prio,
  input  logic                             irq_ack,
  input  logic                             irq_done,
  output logic [NR_PRIO_BITS-1:0]          threshold,
  output logic [$clog2(NEST_DEPTH+1)-1:0]  nest_depth,
  output logic                             busy
);
  localparam int NR_SLOTS = 2**NR_INDEX_BITS;
  localparam int NR_LINES = NR_SLOTS - 1;
  localparam int DW = $clog2(NEST_DEPTH+1);
  localparam int MAXB =
    (NR_PRIO_BITS > NR_INDEX_BITS) ? NR_PRIO_BITS : NR_INDEX_BITS;
  localparam int SW = $clog2(MAXB+1);
  localparam logic [NR_INDEX_BITS-1:0] RSV = NR_INDEX_BITS'(NR_LINES);

  typedef enum logic [1:0] {IDLE, ARB_PRIO, ARB_IDX, OFFER} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           step_q, step_d;
  logic [NR_SLOTS-1:0]     cand_q, cand_d, bitv, filt;
  logic [NR_PRIO_BITS-1:0] snap_q [NR_SLOTS];
  logic [NR_PRIO_BITS-1:0] prio_q [NR_LINES];
  logic [NR_PRIO_BITS-1:0] stk_q [NEST_DEPTH];
  logic [NR_LINES-1:0]     pend_q, en_q, req_en, clr;
  logic [NR_PRIO_BITS-1:0] thr_q, off_prio_q;
  logic [DW-1:0]           depth_q;
  logic [NR_INDEX_BITS-1:0] off_idx_q, win;
  logic                    hs, pop, start, last;

  assign req_en = pend_q & en_q;
  assign hs     = (state_q == OFFER) && irq_ack && !irq_done;
  assign pop    = irq_done && (depth_q != '0);
  assign start  = (|req_en) && (depth_q < DW'(NEST_DEPTH));
  assign last   = (step_q == '0);

  // Wired-OR bit: contenders showing 0 drop only if someone shows 1
  always_comb begin
    bitv = '0;
    for (int i = 0; i < NR_SLOTS; i++) begin
      if (state_q == ARB_PRIO)
        bitv[i] = |(snap_q[i] & (NR_PRIO_BITS'(1) << step_q));
      else
        bitv[i] = |(NR_INDEX_BITS'(i) & (NR_INDEX_BITS'(1) << step_q));
    end
  end

  assign filt = (|(cand_q & bitv)) ? (cand_q & bitv) : cand_q;

  always_comb begin
    win = '0;
    for (int i = 0; i < NR_SLOTS; i++)
      if (filt[i]) win = NR_INDEX_BITS'(i);
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NR_LINES; i++)
      if (hs && off_idx_q == NR_INDEX_BITS'(i)) clr[i] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cand_d  = cand_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ARB_PRIO;
        step_d  = SW'(NR_PRIO_BITS-1);
        cand_d  = {1'b1, req_en};
      end
      ARB_PRIO: begin
        cand_d = filt;
        if (last) begin
          state_d = ARB_IDX;
          step_d  = SW'(NR_INDEX_BITS-1);
        end else begin
          step_d = step_q - SW'(1);
        end
      end
      ARB_IDX: begin
        cand_d = filt;
        if (last) state_d = (win == RSV) ? IDLE : OFFER;
        else      step_d  = step_q - SW'(1);
      end
      OFFER: if (hs || irq_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      cand_q     <= '0;
      off_idx_q  <= '0;
      off_prio_q <= '0;
      for (int i = 0; i < NR_SLOTS; i++) snap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cand_q  <= cand_d;
      if (state_q == IDLE && start) begin
        for (int i = 0; i < NR_LINES; i++) snap_q[i] <= prio_q[i];
        snap_q[NR_SLOTS-1] <= thr_q;
      end
      if (state_q == ARB_IDX && last && win != RSV) begin
        off_idx_q  <= win;
        off_prio_q <= snap_q[win];
      end
    end
  end

  // Set wins over the handshake clear on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      en_q   <= '0;
      for (int i = 0; i < NR_LINES; i++) prio_q[i] <= '0;
    end else begin
      pend_q <= (pend_q & ~clr) | irq_req;
      if (cfg_we) begin
        for (int i = 0; i < NR_LINES; i++) begin
          if (cfg_idx == NR_INDEX_BITS'(i)) begin
            prio_q[i] <= cfg_prio;
            en_q[i]   <= cfg_en;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q   <= '0;
      depth_q <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) stk_q[i] <= '0;
    end else if (hs) begin
      for (int i = 0; i < NEST_DEPTH; i++)
        if (depth_q == DW'(i)) stk_q[i] <= thr_q;
      thr_q   <= off_prio_q;
      depth_q <= depth_q + DW'(1);
    end else if (pop) begin
      for (int i = 0; i < NEST_DEPTH; i++)
        if (depth_q == DW'(i+1)) thr_q <= stk_q[i];
      depth_q <= depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == ARB_IDX && last)
      assert ($onehot(filt));
  end

  assign irq_valid  = (state_q == OFFER);
  assign irq_index  = off_idx_q;
  assign irq_prio   = off_prio_q;
  assign threshold  = thr_q;
  assign nest_depth = depth_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_clic_dispatch.sv
// Bench for clic_dispatch: two instances (stack depth 4 and 1) checked
// every cycle against a transaction-level model, plus directed cases.
module tb_clic_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] irq_req = '0;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [2:0] cfg_prio = '0;
  logic cfg_en = 1'b0;
  logic irq_ack = 1'b0;
  logic irq_done = 1'b0;

  logic v0, v1, b0, b1;
  logic [2:0] i0, i1, p0, p1, t0, t1;
  logic [2:0] n0;
  logic [0:0] n1;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  clic_dispatch u0 (
    .clk(clk), .rst(rst), .irq_req(irq_req),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_prio(cfg_prio),
    .cfg_en(cfg_en), .irq_valid(v0), .irq_index(i0),
    .irq_prio(p0), .irq_ack(irq_ack), .irq_done(irq_done),
    .threshold(t0), .nest_depth(n0), .busy(b0)
  );

  clic_dispatch #(.NEST_DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .irq_req(irq_req),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_prio(cfg_prio),
    .cfg_en(cfg_en), .irq_valid(v1), .irq_index(i1),
    .irq_prio(p1), .irq_ack(irq_ack), .irq_done(irq_done),
    .threshold(t1), .nest_depth(n1), .busy(b1)
  );

  // Model: phase 0 idle, 1 arbitrating (countdown), 2 offering
  logic [6:0] m_pend [2];
  logic [6:0] m_en [2];
  int m_prio [2][7];
  int m_stk [2][4];
  int m_thr [2], m_depth [2], m_ph [2], m_cnt [2];
  int m_res [2], m_rp [2], m_oidx [2], m_oprio [2];

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0; m_en[m] = '0;
      m_thr[m] = 0; m_depth[m] = 0; m_ph[m] = 0; m_cnt[m] = 0;
      m_res[m] = 0; m_rp[m] = 0; m_oidx[m] = 0; m_oprio[m] = 0;
      for (int i = 0; i < 7; i++) m_prio[m][i] = 0;
      for (int i = 0; i < 4; i++) m_stk[m][i] = 0;
    end
  endtask

  task automatic mstep(int m, int dmax);
    logic [6:0] pe, clr;
    int best, bkey, key;
    pe = m_pend[m] & m_en[m];
    clr = '0;
    case (m_ph[m])
      0: if (pe != 0 && m_depth[m] < dmax) begin
        // Highest (prio, index) wins; the reserved slot 7 carries threshold
        best = 7;
        bkey = m_thr[m] * 8 + 7;
        for (int i = 0; i < 7; i++) begin
          key = m_prio[m][i] * 8 + i;
          if (pe[i] && key > bkey) begin bkey = key; best = i; end
        end
        m_res[m] = best;
        m_rp[m] = (best == 7) ? 0 : m_prio[m][best];
        m_ph[m] = 1;
        m_cnt[m] = 6;
      end
      1: begin
        m_cnt[m]--;
        if (m_cnt[m] == 0) begin
          if (m_res[m] == 7) m_ph[m] = 0;
          else begin
            m_ph[m] = 2; m_oidx[m] = m_res[m]; m_oprio[m] = m_rp[m];
          end
        end
      end
      default: if (irq_done) m_ph[m] = 0;
      else if (irq_ack) begin
        clr[m_oidx[m]] = 1'b1;
        m_stk[m][m_depth[m]] = m_thr[m];
        m_depth[m]++;
        m_thr[m] = m_oprio[m];
        m_ph[m] = 0;
      end
    endcase
    if (irq_done && m_depth[m] > 0 && !(m_ph[m] == 0 && clr != 0)) begin
      m_depth[m]--;
      m_thr[m] = m_stk[m][m_depth[m]];
    end
    m_pend[m] = (m_pend[m] & ~clr) | irq_req;
    if (cfg_we && cfg_idx != 3'd7) begin
      m_prio[m][cfg_idx] = int'(cfg_prio);
      m_en[m][cfg_idx] = cfg_en;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) mreset();
    else begin
      mstep(0, 4);
      mstep(1, 1);
    end
  end

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp(int m, int v, int ix, int pr, int th, int nd, int bz);
    int mv;
    mv = (m_ph[m] == 2) ? 1 : 0;
    chk($sformatf("u%0d.valid", m), v, mv);
    if (mv == 1) begin
      chk($sformatf("u%0d.index", m), ix, m_oidx[m]);
      chk($sformatf("u%0d.prio", m), pr, m_oprio[m]);
    end
    chk($sformatf("u%0d.threshold", m), th, m_thr[m]);
    chk($sformatf("u%0d.depth", m), nd, m_depth[m]);
    chk($sformatf("u%0d.busy", m), bz, (m_ph[m] != 0) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      cmp(0, v0, i0, p0, t0, int'(n0), b0);
      cmp(1, v1, i1, p1, t1, int'(n1), b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    irq_req = '0; cfg_we = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg(int idx, int pr, int en);
    cfg_we = 1'b1;
    cfg_idx = 3'(idx); cfg_prio = 3'(pr); cfg_en = 1'(en);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(logic [6:0] mask);
    irq_req = mask;
    tick();
    irq_req = '0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic wait_offer(int m, int idx, int pr, string nm);
    int seen;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      if ((m == 0) ? v0 : v1) seen = 1;
      else tick();
    end
    chk({nm, ".offered"}, seen, 1);
    if (seen == 1) begin
      chk({nm, ".index"}, int'((m == 0) ? i0 : i1), idx);
      chk({nm, ".prio"}, int'((m == 0) ? p0 : p1), pr);
    end
  endtask

  // Counts cycles with an offer (and optionally busy) over n cycles
  task automatic quiet(int m, int n, int with_busy, string nm);
    int seen;
    seen = 0;
    repeat (n) begin
      tick();
      if ((m == 0) ? v0 : v1) seen++;
      if (with_busy != 0 && ((m == 0) ? b0 : b1)) seen++;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_cmp = 1'b1;
    chk("reset.valid", int'(v0), 0);
    chk("reset.busy", int'(b0), 0);

    // Asynchronous reset mid-cycle while a handler is active
    cfg(2, 5, 1);
    pulse(7'h04);
    wait_offer(0, 2, 5, "pre");
    ack();
    chk("pre.thr", int'(t0), 5);
    cfg(6, 7, 1);
    pulse(7'h40);
    tick();
    chk("pre.busy", int'(b0), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", int'(v0), 0);
    chk("arst.thr", int'(t0), 0);
    chk("arst.depth", int'(n0), 0);
    chk("arst.busy", int'(b0), 0);
    @(negedge clk);
    rst = 1'b0;
    quiet(0, 5, 1, "idle.noreq");

    // Single line, exact latency
    cfg(2, 5, 1);
    pulse(7'h04);
    repeat (6) tick();
    chk("single.early", int'(v0), 0);
    tick();
    chk("single.valid", int'(v0), 1);
    chk("single.index", int'(i0), 2);
    chk("single.prio", int'(p0), 5);
    ack();
    chk("single.drop", int'(v0), 0);
    chk("single.thr", int'(t0), 5);
    chk("single.depth", int'(n0), 1);

    // Tie on priority: higher index first, equal prio never preempts
    do_reset();
    cfg(3, 4, 1);
    cfg(5, 4, 1);
    pulse(7'h28);
    wait_offer(0, 5, 4, "tie.first");
    ack();
    chk("tie.thr", int'(t0), 4);
    quiet(0, 20, 0, "tie.equal");
    done();
    chk("tie.pop_thr", int'(t0), 0);
    chk("tie.pop_depth", int'(n0), 0);
    wait_offer(0, 3, 4, "tie.second");

    // Preemption on u0; u1 has a one-entry stack and must hold off
    do_reset();
    cfg(1, 2, 1);
    cfg(6, 6, 1);
    pulse(7'h02);
    wait_offer(0, 1, 2, "pre.l1");
    ack();
    chk("pre.l1.thr", int'(t0), 2);
    chk("full.l1.thr", int'(t1), 2);
    pulse(7'h40);
    wait_offer(0, 6, 6, "pre.l6");
    quiet(1, 10, 0, "full.hold");
    ack();
    chk("pre.depth2", int'(n0), 2);
    chk("pre.thr6", int'(t0), 6);
    chk("full.depth1", int'(n1), 1);
    done();
    chk("pre.pop1.thr", int'(t0), 2);
    chk("pre.pop1.depth", int'(n0), 1);
    done();
    chk("pre.pop2.thr", int'(t0), 0);
    chk("pre.pop2.depth", int'(n0), 0);
    wait_offer(1, 6, 6, "full.release");

    // Enable gating
    do_reset();
    cfg(4, 3, 0);
    pulse(7'h10);
    quiet(0, 15, 1, "gate.off");
    cfg(4, 3, 1);
    repeat (6) tick();
    chk("gate.early", int'(v0), 0);
    tick();
    chk("gate.valid", int'(v0), 1);
    chk("gate.index", int'(i0), 4);

    // Withdrawal: done beats ack, line stays pending
    do_reset();
    cfg(1, 1, 1);
    pulse(7'h02);
    wait_offer(0, 1, 1, "wd.l1");
    ack();
    cfg(2, 5, 1);
    pulse(7'h04);
    wait_offer(0, 2, 5, "wd.first");
    irq_done = 1'b1;
    irq_ack = 1'b1;
    tick();
    irq_done = 1'b0;
    irq_ack = 1'b0;
    chk("wd.valid", int'(v0), 0);
    chk("wd.depth", int'(n0), 0);
    chk("wd.thr", int'(t0), 0);
    wait_offer(0, 2, 5, "wd.again");

    // Randomized traffic against the model
    do_reset();
    repeat (3000) begin
      irq_req = ($urandom % 8 == 0) ? 7'($urandom) : 7'h00;
      cfg_we = ($urandom % 6 == 0);
      cfg_idx = 3'($urandom);
      cfg_prio = 3'($urandom);
      cfg_en = ($urandom % 4 != 0);
      irq_ack = ($urandom % 3 == 0);
      irq_done = ($urandom % 25 == 0);
      tick();
    end
    irq_req = '0; cfg_we = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
